// File: rtl/br_lite_local_if.sv
// br_lite_local_if
//
// Local-port adapter between a processing element (PE) and the BrLite
// router's local port.
//
//   TX path: the PE pushes {target, service, payload} requests over
//   valid/ready into a small FIFO. A TX FSM stamps them with this PE's
//   address and a rolling sequence id. It then injects them into the
//   router's local input with a 4-phase req/ack handshake, waiting while
//   the router reports its local port busy. CLEAR requests are discarded,
//   because the router generates clears itself.
//
//   RX path: flits delivered by the router's local output are acked via a
//   4-phase handshake and pushed into a show-ahead FIFO, which is presented
//   to the PE over valid/ready. CLEAR flits are acked and dropped. While
//   the FIFO is full, no ack is given, so the router stalls.
//
// Flit layout (br_data_t, 74 bits, MSB first):
//   [73:42] payload  [41:26] target  [25:10] source  [9:2] id  [1:0] service
// Service codes: 2'd0 = BR_SVC_ALL, 2'd1 = BR_SVC_TGT, 2'd2 = BR_SVC_CLEAR.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   tx_valid_i / tx_ready_o  PE request handshake (ready = TX FIFO not full)
//   tx_target_i [15:0]       target address
//   tx_service_i [1:0]       service code
//   tx_payload_i [31:0]      payload
//   rx_valid_o / rx_ready_i  PE delivery handshake (valid = RX FIFO non-empty)
//   rx_data_o [73:0]         RX FIFO head flit
//   br_req_o, br_ack_i       4-phase handshake into the router local input
//   br_flit_o [73:0]         flit presented to the router local input
//   br_busy_i                router local-busy window
//   br_req_i, br_ack_o       4-phase handshake from the router local output
//   br_flit_i [73:0]         flit delivered by the router

module br_lite_local_if #(
  parameter logic [15:0] ADDRESS  = 16'h0000,
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [15:0] tx_target_i,
  input  logic [1:0]  tx_service_i,
  input  logic [31:0] tx_payload_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [73:0] rx_data_o,
  output logic        br_req_o,
  input  logic        br_ack_i,
  output logic [73:0] br_flit_o,
  input  logic        br_busy_i,
  input  logic        br_req_i,
  output logic        br_ack_o,
  input  logic [73:0] br_flit_i
);

  localparam logic [1:0] SVC_CLEAR = 2'd2;

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;

  // ---------------------------------------------------------------------
  // TX FIFO: entries are {target[49:34], service[33:32], payload[31:0]}
  // ---------------------------------------------------------------------
  logic [49:0]      tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic             tx_push;
  logic             tx_pop;
  logic [49:0]      tx_head;
  logic [1:0]       tx_head_svc;

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_RELEASE} tx_state_t;
  tx_state_t tx_state;

  logic [7:0]  id_cnt;
  logic        br_req;
  logic [73:0] br_flit;

  assign tx_ready_o  = (tx_count != TX_CW'(TX_DEPTH));
  assign tx_push     = tx_valid_i && tx_ready_o;
  assign tx_head     = tx_mem[tx_rd_ptr];
  assign tx_head_svc = tx_head[33:32];

  // The head leaves the FIFO either to be discarded (CLEAR, busy does not
  // matter) or to be injected (only outside the router's busy window).
  assign tx_pop = (tx_state == TX_IDLE) && (tx_count != '0) &&
                  ((tx_head_svc == SVC_CLEAR) || !br_busy_i);

  always_ff @(posedge clk_i) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= {tx_target_i, tx_service_i, tx_payload_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX FSM. br_flit is loaded only on the IDLE->REQ transition, so it stays
  // stable for the whole handshake and until the next injection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state <= TX_IDLE;
      br_req   <= 1'b0;
      br_flit  <= '0;
      id_cnt   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop && (tx_head_svc != SVC_CLEAR)) begin
            br_flit  <= {tx_head[31:0], tx_head[49:34], ADDRESS, id_cnt,
                         tx_head_svc};
            id_cnt   <= id_cnt + 8'd1;
            br_req   <= 1'b1;
            tx_state <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (br_ack_i) begin
            br_req   <= 1'b0;
            tx_state <= TX_RELEASE;
          end
        end
        TX_RELEASE: begin
          // Wait for the router to drop ack before considering the next flit.
          if (!br_ack_i) tx_state <= TX_IDLE;
        end
        default: begin
          br_req   <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign br_req_o  = br_req;
  assign br_flit_o = br_flit;

  // ---------------------------------------------------------------------
  // RX FIFO (show-ahead) and RX FSM
  // ---------------------------------------------------------------------
  logic [73:0]      rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;
  logic             rx_full;
  logic             rx_accept;
  logic             rx_push;
  logic             rx_pop;

  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
  rx_state_t rx_state;
  logic      br_ack;

  assign rx_full    = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_valid_o = (rx_count != '0);
  // Gate the head with valid so the output reads zero when the FIFO is empty.
  assign rx_data_o  = rx_valid_o ? rx_mem[rx_rd_ptr] : '0;
  assign rx_pop     = rx_valid_o && rx_ready_i;

  // A request is accepted (acked) only when there is room; CLEAR flits are
  // acked like any other but never stored.
  assign rx_accept = (rx_state == RX_IDLE) && br_req_i && !rx_full;
  assign rx_push   = rx_accept && (br_flit_i[1:0] != SVC_CLEAR);

  always_ff @(posedge clk_i) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= br_flit_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Ack is held until the router drops req; returning to IDLE only after
  // req is low guarantees the same request is never acked twice.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state <= RX_IDLE;
      br_ack   <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_accept) begin
            br_ack   <= 1'b1;
            rx_state <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (!br_req_i) begin
            br_ack   <= 1'b0;
            rx_state <= RX_IDLE;
          end
        end
        default: begin
          br_ack   <= 1'b0;
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign br_ack_o = br_ack;

endmodule

// File: tb/tb_br_lite_local_if.sv
// tb_br_lite_local_if
//
// Directed bench for br_lite_local_if with ADDRESS=16'h0201. The bench
// plays both the PE and the router's local port. Expected flits are built
// from the documented field layout:
//   {payload[31:0], target[15:0], source[15:0], id[7:0], service[1:0]}

module tb_br_lite_local_if;

  localparam logic [15:0] ADDR      = 16'h0201;
  localparam int          TXD       = 4;
  localparam int          RXD       = 4;
  localparam logic [1:0]  SVC_ALL   = 2'd0;
  localparam logic [1:0]  SVC_TGT   = 2'd1;
  localparam logic [1:0]  SVC_CLEAR = 2'd2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [15:0] tx_target_i = '0;
  logic [1:0]  tx_service_i = '0;
  logic [31:0] tx_payload_i = '0;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic [73:0] rx_data_o;
  logic        br_req_o;
  logic        br_ack_i = 1'b0;
  logic [73:0] br_flit_o;
  logic        br_busy_i = 1'b0;
  logic        br_req_i = 1'b0;
  logic        br_ack_o;
  logic [73:0] br_flit_i = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_id = 8'd0;
  logic [73:0] rx_exp [RXD+1];
  logic [73:0] held;

  br_lite_local_if #(
    .ADDRESS (ADDR),
    .TX_DEPTH(TXD),
    .RX_DEPTH(RXD)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .tx_target_i (tx_target_i),
    .tx_service_i(tx_service_i),
    .tx_payload_i(tx_payload_i),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .rx_data_o   (rx_data_o),
    .br_req_o    (br_req_o),
    .br_ack_i    (br_ack_i),
    .br_flit_o   (br_flit_o),
    .br_busy_i   (br_busy_i),
    .br_req_i    (br_req_i),
    .br_ack_o    (br_ack_o),
    .br_flit_i   (br_flit_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [73:0] mk(input logic [15:0] src, input logic [7:0] id,
                                     input logic [15:0] tgt, input logic [1:0] svc,
                                     input logic [31:0] pay);
    return {pay, tgt, src, id, svc};
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // PE push; returns #1 after the edge that captured the request.
  task automatic push(input logic [15:0] tgt, input logic [1:0] svc, input logic [31:0] pay);
    int n;
    tx_target_i  = tgt;
    tx_service_i = svc;
    tx_payload_i = pay;
    tx_valid_i   = 1'b1;
    n = 0;
    while (!tx_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("push_timeout", 80'(tx_ready_o), 80'(1));
    tick();
    tx_valid_i = 1'b0;
    $display("push tgt=%h svc=%0d pay=%h", tgt, svc, pay);
  endtask

  // Router side of one injection: wait for req, check the flit, ack it
  // (optionally raising busy together with the ack), then release.
  task automatic inject_expect(input string tag, input logic [15:0] tgt, input logic [1:0] svc,
                               input logic [31:0] pay, input logic raise_busy);
    int n;
    n = 0;
    while (!br_req_o && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 80'(br_req_o), 80'(1));
    check({tag, "_flit"}, 80'(br_flit_o), 80'(mk(ADDR, exp_id, tgt, svc, pay)));
    $display("inject %s id=%0d flit=%h", tag, br_flit_o[9:2], br_flit_o);
    exp_id++;
    br_ack_i  = 1'b1;
    br_busy_i = raise_busy;
    tick();
    check({tag, "_req_fall"}, 80'(br_req_o), 80'(0));
    br_ack_i = 1'b0;
    tick();
  endtask

  // Router delivers one flit on the local output with a full handshake.
  task automatic deliver(input string tag, input logic [73:0] flit);
    int n;
    br_flit_i = flit;
    br_req_i  = 1'b1;
    n = 0;
    while (!br_ack_o && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ack"}, 80'(br_ack_o), 80'(1));
    br_req_i = 1'b0;
    n = 0;
    while (br_ack_o && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ack_fall"}, 80'(br_ack_o), 80'(0));
    $display("deliver %s flit=%h", tag, flit);
  endtask

  initial begin
    // ---------------- reset values ----------------
    #23;
    check("rst_br_req", 80'(br_req_o), 80'(0));
    check("rst_br_ack", 80'(br_ack_o), 80'(0));
    check("rst_br_flit", 80'(br_flit_o), 80'(0));
    check("rst_rx_valid", 80'(rx_valid_o), 80'(0));
    check("rst_rx_data", 80'(rx_data_o), 80'(0));
    check("rst_tx_ready", 80'(tx_ready_o), 80'(1));
    tick();
    rst_ni = 1'b1;
    tick();

    // ---------------- single TX ----------------
    push(16'h0102, SVC_ALL, 32'h0000CAFE);
    check("tx1_req_not_yet", 80'(br_req_o), 80'(0));
    tick();
    check("tx1_req_rise", 80'(br_req_o), 80'(1));
    held = br_flit_o;
    for (int i = 0; i < 3; i++) tick();
    check("tx1_req_held", 80'(br_req_o), 80'(1));
    check("tx1_flit_held", 80'(br_flit_o), 80'(held));
    inject_expect("tx1", 16'h0102, SVC_ALL, 32'h0000CAFE, 1'b0);
    check("tx1_flit_after", 80'(br_flit_o), 80'(mk(ADDR, 8'd0, 16'h0102, SVC_ALL, 32'h0000CAFE)));

    // ---------------- busy gating ----------------
    br_busy_i = 1'b1;
    for (int i = 1; i <= 3; i++) push(16'h0300, SVC_TGT, 32'(i));
    for (int i = 0; i < 4; i++) tick();
    check("busy_no_req", 80'(br_req_o), 80'(0));
    push(16'h0300, SVC_TGT, 32'd4);
    check("busy_tx_full", 80'(tx_ready_o), 80'(0));
    br_busy_i = 1'b0;
    inject_expect("busy1", 16'h0300, SVC_TGT, 32'd1, 1'b1);  // id 1
    for (int i = 0; i < 4; i++) tick();
    check("busy2_waits", 80'(br_req_o), 80'(0));
    check("busy_tx_ready", 80'(tx_ready_o), 80'(1));
    br_busy_i = 1'b0;
    for (int i = 2; i <= 4; i++) inject_expect($sformatf("busy%0d", i), 16'h0300, SVC_TGT, 32'(i), 1'b0);

    // ---------------- CLEAR filtering ----------------
    push(16'h0304, SVC_CLEAR, 32'd9);
    push(16'h0304, SVC_ALL, 32'd5);
    inject_expect("clr_next", 16'h0304, SVC_ALL, 32'd5, 1'b0);  // id 5, CLEAR skipped
    for (int i = 0; i < 4; i++) tick();
    check("clr_no_more_req", 80'(br_req_o), 80'(0));
    deliver("rx_clr", mk(16'h0a0b, 8'd7, ADDR, SVC_CLEAR, 32'h77));
    tick();
    check("rx_clr_dropped", 80'(rx_valid_o), 80'(0));

    // ---------------- RX backpressure ----------------
    rx_ready_i = 1'b0;
    for (int i = 0; i <= RXD; i++) rx_exp[i] = mk(16'h0a0b, 8'(i), ADDR, SVC_TGT, 32'h1000 + 32'(i));
    br_flit_i = rx_exp[0];
    br_req_i  = 1'b1;
    tick();
    check("rx0_ack_latency", 80'(br_ack_o), 80'(1));
    check("rx0_valid_latency", 80'(rx_valid_o), 80'(1));
    check("rx0_data_latency", 80'(rx_data_o), 80'(rx_exp[0]));
    br_req_i = 1'b0;
    tick();
    check("rx0_ack_fall", 80'(br_ack_o), 80'(0));
    for (int i = 1; i < RXD; i++) deliver($sformatf("rx%0d", i), rx_exp[i]);
    br_flit_i = rx_exp[RXD];
    br_req_i  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rx_full_no_ack", 80'(br_ack_o), 80'(0));
    check("rx_full_head", 80'(rx_data_o), 80'(rx_exp[0]));
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    tick();
    check("rx_ack_after_pop", 80'(br_ack_o), 80'(1));
    br_req_i = 1'b0;
    tick();
    check("rx_ack_fall_after_pop", 80'(br_ack_o), 80'(0));
    rx_ready_i = 1'b1;
    for (int i = 1; i <= RXD; i++) begin
      check($sformatf("rx_order%0d_valid", i), 80'(rx_valid_o), 80'(1));
      check($sformatf("rx_order%0d_data", i), 80'(rx_data_o), 80'(rx_exp[i]));
      $display("pop rx%0d data=%h", i, rx_data_o);
      tick();
    end
    rx_ready_i = 1'b0;
    check("rx_drained", 80'(rx_valid_o), 80'(0));

    // ---------------- reset mid-handshake ----------------
    push(16'h0555, SVC_ALL, 32'hABCD);
    br_flit_i = mk(16'h0a0b, 8'd9, ADDR, SVC_ALL, 32'h99);
    br_req_i  = 1'b1;
    tick();
    tick();
    check("mid_br_req", 80'(br_req_o), 80'(1));
    check("mid_br_ack", 80'(br_ack_o), 80'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_br_req", 80'(br_req_o), 80'(0));
    check("arst_br_ack", 80'(br_ack_o), 80'(0));
    check("arst_br_flit", 80'(br_flit_o), 80'(0));
    check("arst_rx_valid", 80'(rx_valid_o), 80'(0));
    check("arst_rx_data", 80'(rx_data_o), 80'(0));
    check("arst_tx_ready", 80'(tx_ready_o), 80'(1));
    br_req_i = 1'b0;
    br_ack_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    exp_id = 8'd0;
    tick();

    // ---------------- id wrap: 0..255, 0 ----------------
    for (int i = 0; i <= 256; i++) begin
      push(16'h0600, SVC_TGT, 32'h2000 + 32'(i));
      inject_expect($sformatf("wrap%0d", i), 16'h0600, SVC_TGT, 32'h2000 + 32'(i), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
